// File: rtl/sme_feeder.sv
// -----------------------------------------------------------------------------
// sme_feeder
//   Upstream loader for the string-matching engine. It collects one job of
//   string and pattern bytes from a valid/ready byte stream. It replays the job
//   into the engine's isstring/ispattern/chardata interface. It then waits for
//   the engine's valid and returns a registered one-cycle result with an error
//   flag.
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   i_in_valid    in   upstream byte valid
//   o_in_ready    out  feeder can accept a byte (LOAD state only)
//   i_in_data     in   ASCII byte
//   i_in_type     in   0 = string field, 1 = pattern field
//   i_in_last     in   byte ends the current field
//   o_isstring    out  engine strobe: chardata is a string byte
//   o_ispattern   out  engine strobe: chardata is a pattern byte
//   o_chardata    out  byte presented to the engine (0 when idle)
//   i_sme_valid   in   engine result valid
//   i_sme_match   in   engine match flag
//   i_sme_index   in   engine match index
//   o_res_valid   out  one-cycle result strobe
//   o_res_match   out  registered match, held until the next result
//   o_res_index   out  registered index, held until the next result
//   o_res_err     out  job saw an overflow or a timeout
// -----------------------------------------------------------------------------
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_in_data,
  input  logic       i_in_type,
  input  logic       i_in_last,
  output logic       o_isstring,
  output logic       o_ispattern,
  output logic [7:0] o_chardata,
  input  logic       i_sme_valid,
  input  logic       i_sme_match,
  input  logic [4:0] i_sme_index,
  output logic       o_res_valid,
  output logic       o_res_match,
  output logic [4:0] o_res_index,
  output logic       o_res_err
);

  localparam int STR_AW = $clog2(STR_MAX);
  localparam int PAT_AW = $clog2(PAT_MAX);
  localparam int SLEN_W = $clog2(STR_MAX + 1);
  localparam int PLEN_W = $clog2(PAT_MAX + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_SEND_STR,
    S_SEND_PAT,
    S_WAIT_RES,
    S_RESULT
  } state_t;

  state_t              r_state;
  logic [7:0]          r_str_buf [STR_MAX];
  logic [7:0]          r_pat_buf [PAT_MAX];
  logic [SLEN_W-1:0]   r_str_len;
  logic [PLEN_W-1:0]   r_pat_len;
  logic                r_has_str;
  logic                r_str_open;   // inside a string field (no in_last seen yet)
  logic                r_err;
  logic [SLEN_W-1:0]   r_idx;        // index of the next byte to present
  logic [TMO_W-1:0]    r_tmo;
  logic                r_isstring;
  logic                r_ispattern;
  logic [7:0]          r_chardata;
  logic                r_res_valid;
  logic                r_res_match;
  logic [4:0]          r_res_index;
  logic                r_res_err;

  logic                w_xfer;
  logic                w_str_xfer;
  logic                w_pat_xfer;
  logic [SLEN_W-1:0]   w_str_base;
  logic                w_str_full;
  logic                w_pat_full;
  logic                w_str_we;
  logic                w_pat_we;
  logic [7:0]          w_pat_first;
  logic [7:0]          w_str_rd;
  logic [7:0]          w_pat_rd;
  logic                w_str_more;
  logic                w_pat_more;

  assign w_xfer     = i_in_valid && (r_state == S_LOAD);
  assign w_str_xfer = w_xfer && !i_in_type;
  assign w_pat_xfer = w_xfer && i_in_type;

  // A byte that opens a new string field writes at 0 whatever str_len holds.
  assign w_str_base = r_str_open ? r_str_len : '0;
  assign w_str_full = (w_str_base == SLEN_W'(STR_MAX));
  assign w_pat_full = (r_pat_len == PLEN_W'(PAT_MAX));
  assign w_str_we   = w_str_xfer && !w_str_full;
  assign w_pat_we   = w_pat_xfer && !w_pat_full;

  // For a pattern-only job of one byte, the first byte is being written on
  // the same edge that starts the replay, so forward it from the input.
  assign w_pat_first = (r_pat_len == '0) ? i_in_data : r_pat_buf[0];

  assign w_str_rd   = r_str_buf[r_idx[STR_AW-1:0]];
  assign w_pat_rd   = r_pat_buf[r_idx[PAT_AW-1:0]];
  assign w_str_more = (r_idx < r_str_len);
  assign w_pat_more = (r_idx < SLEN_W'(r_pat_len));

  // ---------------------------------------------------------------------------
  // Job buffers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STR_MAX; i++) r_str_buf[i] <= '0;
      for (int i = 0; i < PAT_MAX; i++) r_pat_buf[i] <= '0;
    end else begin
      if (w_str_we) r_str_buf[w_str_base[STR_AW-1:0]] <= i_in_data;
      if (w_pat_we) r_pat_buf[r_pat_len[PAT_AW-1:0]]  <= i_in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered engine strobes and result outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_LOAD;
      r_str_len   <= '0;
      r_pat_len   <= '0;
      r_has_str   <= 1'b0;
      r_str_open  <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      r_chardata  <= '0;
      r_res_valid <= 1'b0;
      r_res_match <= 1'b0;
      r_res_index <= '0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_str_xfer) begin
            if (w_str_full) r_err <= 1'b1;
            else            r_str_len <= w_str_base + SLEN_W'(1);
            if (!r_str_open) r_has_str <= 1'b1;
            r_str_open <= !i_in_last;
          end
          if (w_pat_xfer) begin
            // A pattern byte closes any open string field, so a later string
            // byte starts a fresh field.
            r_str_open <= 1'b0;
            if (w_pat_full) r_err <= 1'b1;
            else            r_pat_len <= r_pat_len + PLEN_W'(1);
            if (i_in_last) begin
              // Present the first byte on this edge so the engine sees it in
              // the cycle right after the job completes.
              r_idx <= SLEN_W'(1);
              if (r_has_str) begin
                r_state    <= S_SEND_STR;
                r_isstring <= 1'b1;
                r_chardata <= r_str_buf[0];
              end else begin
                r_state     <= S_SEND_PAT;
                r_ispattern <= 1'b1;
                r_chardata  <= w_pat_first;
              end
            end
          end
        end

        S_SEND_STR: begin
          if (w_str_more) begin
            r_chardata <= w_str_rd;
            r_idx      <= r_idx + SLEN_W'(1);
          end else begin
            // Hand over to the pattern with no idle cycle in between.
            r_state     <= S_SEND_PAT;
            r_isstring  <= 1'b0;
            r_ispattern <= 1'b1;
            r_chardata  <= r_pat_buf[0];
            r_idx       <= SLEN_W'(1);
          end
        end

        S_SEND_PAT: begin
          if (w_pat_more) begin
            r_chardata <= w_pat_rd;
            r_idx      <= r_idx + SLEN_W'(1);
          end else begin
            r_state     <= S_WAIT_RES;
            r_ispattern <= 1'b0;
            r_chardata  <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
          end
        end

        S_WAIT_RES: begin
          if (i_sme_valid) begin
            r_state     <= S_RESULT;
            r_res_valid <= 1'b1;
            r_res_match <= i_sme_match;
            r_res_index <= i_sme_index;
            r_res_err   <= r_err;
          end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
            // This wait cycle brings the count to TIMEOUT: abandon the job.
            r_state     <= S_RESULT;
            r_res_valid <= 1'b1;
            r_res_match <= 1'b0;
            r_res_index <= '0;
            r_res_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        S_RESULT: begin
          // str_len is kept so the engine-side string can be reused, but
          // has_str is cleared so it is not replayed without a new field.
          r_state     <= S_LOAD;
          r_res_valid <= 1'b0;
          r_has_str   <= 1'b0;
          r_str_open  <= 1'b0;
          r_pat_len   <= '0;
          r_err       <= 1'b0;
        end

        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_LOAD);
  assign o_isstring  = r_isstring;
  assign o_ispattern = r_ispattern;
  assign o_chardata  = r_chardata;
  assign o_res_valid = r_res_valid;
  assign o_res_match = r_res_match;
  assign o_res_index = r_res_index;
  assign o_res_err   = r_res_err;

endmodule

// File: tb/tb_sme_feeder.sv
// -----------------------------------------------------------------------------
// tb_sme_feeder
//   Directed bench for sme_feeder: loads jobs byte by byte, captures the engine
//   strobes and result pulses, and compares them with hand-computed values.
// -----------------------------------------------------------------------------
module tb_sme_feeder;

  localparam int TIMEOUT = 255;

  logic       clk;
  logic       reset_n;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [7:0] i_in_data;
  logic       i_in_type;
  logic       i_in_last;
  logic       o_isstring;
  logic       o_ispattern;
  logic [7:0] o_chardata;
  logic       i_sme_valid;
  logic       i_sme_match;
  logic [4:0] i_sme_index;
  logic       o_res_valid;
  logic       o_res_match;
  logic [4:0] o_res_index;
  logic       o_res_err;

  sme_feeder #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .i_in_type   (i_in_type),
    .i_in_last   (i_in_last),
    .o_isstring  (o_isstring),
    .o_ispattern (o_ispattern),
    .o_chardata  (o_chardata),
    .i_sme_valid (i_sme_valid),
    .i_sme_match (i_sme_match),
    .i_sme_index (i_sme_index),
    .o_res_valid (o_res_valid),
    .o_res_match (o_res_match),
    .o_res_index (o_res_index),
    .o_res_err   (o_res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture of everything the DUT presents, sampled on the falling edge.
  logic [7:0] str_q[$];
  int         str_cyc[$];
  logic [7:0] pat_q[$];
  int         pat_cyc[$];
  int         res_cnt = 0;
  int         res_cyc = 0;
  logic       res_m;
  logic [4:0] res_i;
  logic       res_e;
  int         both_cnt = 0;
  int         idle_cnt = 0;

  always @(negedge clk) begin
    if (o_isstring)  begin str_q.push_back(o_chardata); str_cyc.push_back(cyc); end
    if (o_ispattern) begin pat_q.push_back(o_chardata); pat_cyc.push_back(cyc); end
    if (o_isstring && o_ispattern) both_cnt++;
    if (!o_isstring && !o_ispattern && o_chardata != 8'h00) idle_cnt++;
    if (o_res_valid) begin
      res_cnt++;
      res_cyc = cyc;
      res_m   = o_res_match;
      res_i   = o_res_index;
      res_e   = o_res_err;
    end
  end

  int last_xfer_cyc;

  task automatic clear_caps();
    str_q.delete(); str_cyc.delete(); pat_q.delete(); pat_cyc.delete();
  endtask

  // Called #1 after a rising edge; returns #1 after the transferring edge.
  task automatic send_byte(input logic [7:0] d, input logic t, input logic l);
    int n;
    n = 0;
    i_in_valid = 1'b1; i_in_data = d; i_in_type = t; i_in_last = l;
    while (!o_in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check_val("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    last_xfer_cyc = cyc;
    i_in_valid = 1'b0; i_in_last = 1'b0;
  endtask

  // Pulse the engine valid once and check the forwarded result.
  task automatic pulse_and_check(input string tag, input logic m, input logic [4:0] idx,
                                 input logic exp_err);
    int c0;
    int sc;
    c0 = res_cnt;
    i_sme_valid = 1'b1; i_sme_match = m; i_sme_index = idx;
    @(posedge clk); #1;
    sc = cyc;
    i_sme_valid = 1'b0; i_sme_match = 1'b0; i_sme_index = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, " res_pulses"}, res_cnt - c0, 32'd1);
    check_val({tag, " res_latency"}, res_cyc, sc);
    check_val({tag, " res_match"}, res_m, m);
    check_val({tag, " res_index"}, res_i, idx);
    check_val({tag, " res_err"}, res_e, exp_err);
    check_val({tag, " hold_index"}, o_res_index, idx);
    $display("job %s: match=%0d index=%0d err=%0d at cycle %0d", tag, res_m, res_i, res_e, res_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int sc;
    int n;
    int p_last;
    int rdy_seen;
    int rdy_cyc;

    reset_n = 1'b0; i_in_valid = 1'b0; i_in_data = '0; i_in_type = 1'b0; i_in_last = 1'b0;
    i_sme_valid = 1'b0; i_sme_match = 1'b0; i_sme_index = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check_val("rst in_ready", o_in_ready, 1);
    check_val("rst isstring", o_isstring, 0);
    check_val("rst ispattern", o_ispattern, 0);
    check_val("rst chardata", o_chardata, 0);
    check_val("rst res_valid", o_res_valid, 0);
    check_val("rst res_fields", {o_res_match, o_res_index, o_res_err}, 0);

    // Test 1: string "abc" + pattern "b"
    clear_caps();
    send_byte(8'h61, 1'b0, 1'b0);
    send_byte(8'h62, 1'b0, 1'b0);
    send_byte(8'h63, 1'b0, 1'b1);
    send_byte(8'h62, 1'b1, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check_val("t1 str_count", str_q.size(), 3);
    check_val("t1 str0", str_q[0], 8'h61);
    check_val("t1 str1", str_q[1], 8'h62);
    check_val("t1 str2", str_q[2], 8'h63);
    check_val("t1 pat_count", pat_q.size(), 1);
    check_val("t1 pat0", pat_q[0], 8'h62);
    // First string byte is on the bus in the cycle right after the job edge.
    check_val("t1 start_latency", str_cyc[0], last_xfer_cyc);
    check_val("t1 no_gap", pat_cyc[0], str_cyc[2] + 1);
    pulse_and_check("t1", 1'b1, 5'd1, 1'b0);

    // sme_valid outside WAIT_RES is ignored
    c0 = res_cnt;
    i_sme_valid = 1'b1; i_sme_match = 1'b1; i_sme_index = 5'd9;
    repeat (3) @(posedge clk);
    #1 i_sme_valid = 1'b0; i_sme_match = 1'b0; i_sme_index = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("idle sme_ignored", res_cnt - c0, 0);

    // Test 2: pattern-only "^a"
    clear_caps();
    send_byte(8'h5E, 1'b1, 1'b0);
    send_byte(8'h61, 1'b1, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check_val("t2 str_count", str_q.size(), 0);
    check_val("t2 pat_count", pat_q.size(), 2);
    check_val("t2 pat0", pat_q[0], 8'h5E);
    check_val("t2 pat1", pat_q[1], 8'h61);
    check_val("t2 start_latency", pat_cyc[0], last_xfer_cyc);
    pulse_and_check("t2", 1'b1, 5'd7, 1'b0);

    // Test 3: 34-byte string overflows to 32 bytes, err reported
    clear_caps();
    for (int i = 0; i < 34; i++) send_byte(8'h41 + 8'(i), 1'b0, (i == 33));
    send_byte(8'h42, 1'b1, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check_val("t3 str_count", str_q.size(), 32);
    check_val("t3 str0", str_q[0], 8'h41);
    check_val("t3 str31", str_q[31], 8'h60);
    check_val("t3 pat0", pat_q[0], 8'h42);
    pulse_and_check("t3", 1'b0, 5'd3, 1'b1);

    // Test 4: timeout with sme_valid held low
    clear_caps();
    send_byte(8'h78, 1'b0, 1'b0);
    send_byte(8'h79, 1'b0, 1'b1);
    send_byte(8'h79, 1'b1, 1'b1);
    c0 = res_cnt;
    n = 0;
    while (res_cnt == c0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check_val("t4 res_pulses", res_cnt - c0, 1);
    p_last = pat_cyc[pat_cyc.size() - 1];
    check_val("t4 str_count", str_q.size(), 2);
    check_val("t4 timeout_cycle", res_cyc, p_last + TIMEOUT + 1);
    check_val("t4 res_match", res_m, 0);
    check_val("t4 res_index", res_i, 0);
    check_val("t4 res_err", res_e, 1);
    $display("job t4: timeout result match=%0d index=%0d err=%0d at cycle %0d", res_m, res_i, res_e, res_cyc);

    // Test 5: reset during SEND_STR
    clear_caps();
    for (int i = 0; i < 8; i++) send_byte(8'h61 + 8'(i), 1'b0, (i == 7));
    send_byte(8'h61, 1'b1, 1'b1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_val("t5 rst_isstring", o_isstring, 0);
    check_val("t5 rst_ispattern", o_ispattern, 0);
    check_val("t5 rst_chardata", o_chardata, 0);
    check_val("t5 rst_res_valid", o_res_valid, 0);
    sc = str_q.size();
    c0 = res_cnt;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check_val("t5 in_ready", o_in_ready, 1);
    repeat (300) @(posedge clk);
    #1;
    check_val("t5 no_more_str", str_q.size(), sc);
    check_val("t5 no_pat", pat_q.size(), 0);
    check_val("t5 no_res", res_cnt - c0, 0);
    $display("job t5: abandoned by reset after %0d string bytes", sc);

    // Test 6: in_valid held during WAIT_RES
    clear_caps();
    send_byte(8'h68, 1'b0, 1'b0);
    send_byte(8'h69, 1'b0, 1'b1);
    send_byte(8'h69, 1'b1, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    i_in_valid = 1'b1; i_in_data = 8'h55; i_in_type = 1'b0; i_in_last = 1'b1;
    rdy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_in_ready) rdy_seen++;
    end
    check_val("t6 ready_in_wait", rdy_seen, 0);
    @(posedge clk); #1;
    i_sme_valid = 1'b1; i_sme_match = 1'b1; i_sme_index = 5'd2;
    @(posedge clk); #1;
    sc = cyc;
    i_sme_valid = 1'b0; i_sme_match = 1'b0; i_sme_index = '0;
    rdy_cyc = -1;
    n = 0;
    while (rdy_cyc < 0 && n < 10) begin
      @(negedge clk);
      if (o_in_ready) rdy_cyc = cyc;
      n++;
    end
    check_val("t6 resume_cycle", rdy_cyc, sc + 1);
    check_val("t6 res_cycle", res_cyc, sc);
    check_val("t6 res_index", res_i, 2);
    @(posedge clk); #1;
    i_in_valid = 1'b0; i_in_last = 1'b0;
    clear_caps();
    send_byte(8'h55, 1'b1, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check_val("t6 str_count", str_q.size(), 1);
    check_val("t6 str0", str_q[0], 8'h55);
    check_val("t6 pat0", pat_q[0], 8'h55);
    pulse_and_check("t6", 1'b0, 5'd0, 1'b0);

    // Invariants over the whole run
    check_val("strobes_never_both", both_cnt, 0);
    check_val("idle_chardata_zero", idle_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
